// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - forward-select encoding shared by core decode and trace
package fwd_pkg;

    // Forward source encodings; 2'b11 is never produced and decodes to register file
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    localparam int FWD_SEL_W = 2;

    // Map a raw 2-bit select onto the enum, folding the unused code onto FWD_RF
    function automatic fwd_sel_t fwd_decode(input logic [FWD_SEL_W-1:0] raw);
        fwd_sel_t sel;
        case (raw)
            2'b01:   sel = FWD_W;
            2'b10:   sel = FWD_M;
            default: sel = FWD_RF;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - pipeline-side bundle between the core stages and the forwarding unit
interface fwd_hazard_unit_if #(
    parameter int XLEN  = 32,
    parameter int RAW   = 4,
    parameter int NSRC  = 2,
    parameter int CNT_W = 16
);
    logic [NSRC*RAW-1:0]  rs_d;
    logic [RAW-1:0]       wa_e;
    logic                 we_e;
    logic                 ld_e;
    logic [RAW-1:0]       wa_m;
    logic                 we_m;
    logic                 flush_e;
    logic                 sb_set;
    logic [RAW-1:0]       sb_set_dst;
    logic                 sb_clr;
    logic [RAW-1:0]       sb_clr_dst;
    logic [NSRC*XLEN-1:0] rf_e;
    logic [XLEN-1:0]      alu_out_m;
    logic [XLEN-1:0]      result_w;
    logic [NSRC*XLEN-1:0] src_e;
    logic [NSRC*2-1:0]    sel_e;
    logic                 stall_d;
    logic                 bubble_e;
    logic                 sb_busy;
    logic [CNT_W-1:0]     stall_cnt;

    // Pipeline stages drive register addresses and data, observe forwarded operands and hazards
    modport master (
        output rs_d, wa_e, we_e, ld_e, wa_m, we_m, flush_e,
        output sb_set, sb_set_dst, sb_clr, sb_clr_dst,
        output rf_e, alu_out_m, result_w,
        input  src_e, sel_e, stall_d, bubble_e, sb_busy, stall_cnt
    );

    // Forwarding unit side
    modport slave (
        input  rs_d, wa_e, we_e, ld_e, wa_m, we_m, flush_e,
        input  sb_set, sb_set_dst, sb_clr, sb_clr_dst,
        input  rf_e, alu_out_m, result_w,
        output src_e, sel_e, stall_d, bubble_e, sb_busy, stall_cnt
    );

endinterface

// File: rtl/fwd_hazard_unit_scoreboard.sv
// rtl/fwd_hazard_unit_scoreboard.sv - pending-write bits for long-latency destinations
module fwd_scoreboard #(
    parameter int NREG     = 16,
    parameter int RAW      = 4,
    parameter int ZERO_REG = 0,
    parameter int NSRC     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_set,
    input  logic [RAW-1:0]      i_set_dst,
    input  logic                i_clr,
    input  logic [RAW-1:0]      i_clr_dst,
    input  logic [NSRC*RAW-1:0] i_rs,
    output logic                o_hit,
    output logic                o_busy
);

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_nxt;
    logic            w_hit;

    // Next pending bits: clear first, then set overrides so a same-cycle set+clr leaves the bit pending
    always_comb begin
        w_pending_nxt = r_pending;
        for (int r = 0; r < NREG; r++) begin
            if (i_clr && (i_clr_dst == RAW'(r))) begin
                w_pending_nxt[r] = 1'b0;
            end
            if (i_set && (i_set_dst == RAW'(r)) && !((ZERO_REG != 0) && (r == 0))) begin
                w_pending_nxt[r] = 1'b1;
            end
        end
    end

    // Pending register; the clear becomes visible to lookups one cycle after completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Lookup every source channel against the registered pending bits
    always_comb begin
        w_hit = 1'b0;
        for (int ch = 0; ch < NSRC; ch++) begin
            for (int r = 0; r < NREG; r++) begin
                if ((i_rs[ch*RAW +: RAW] == RAW'(r)) && r_pending[r]) begin
                    w_hit = 1'b1;
                end
            end
        end
    end

    assign o_hit  = w_hit;
    assign o_busy = |r_pending;

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forward-select generation, EX operand muxes, load-use/scoreboard stall
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 16,
    parameter int RAW      = $clog2(NREG),
    parameter int NSRC     = 2,
    parameter int ZERO_REG = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fwd_hazard_unit_if.slave bus
);

    fwd_sel_t         w_next_sel [NSRC];
    fwd_sel_t         r_sel_e    [NSRC];
    logic [XLEN-1:0]  w_src      [NSRC];
    logic [NSRC-1:0]  w_load_use_ch;
    logic             w_sb_hit;
    logic             w_hazard;
    logic             w_clear_sel;
    logic [CNT_W-1:0] r_stall_cnt;

    fwd_scoreboard #(
        .NREG     (NREG),
        .RAW      (RAW),
        .ZERO_REG (ZERO_REG),
        .NSRC     (NSRC)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_set     (bus.sb_set),
        .i_set_dst (bus.sb_set_dst),
        .i_clr     (bus.sb_clr),
        .i_clr_dst (bus.sb_clr_dst),
        .i_rs      (bus.rs_d),
        .o_hit     (w_sb_hit),
        .o_busy    (bus.sb_busy)
    );

    for (genvar ch = 0; ch < NSRC; ch++) begin : g_chan
        logic [RAW-1:0] w_rs;
        logic           w_rs_zero;

        assign w_rs      = bus.rs_d[ch*RAW +: RAW];
        assign w_rs_zero = (ZERO_REG != 0) && (w_rs == '0);

        // Decode-stage select: E producer wins (it sits in M next cycle), then M producer (in W next cycle)
        always_comb begin
            w_next_sel[ch] = FWD_RF;
            if (!w_rs_zero) begin
                if ((w_rs == bus.wa_e) && bus.we_e && !bus.ld_e) begin
                    w_next_sel[ch] = FWD_M;
                end else if ((w_rs == bus.wa_m) && bus.we_m) begin
                    w_next_sel[ch] = FWD_W;
                end
            end
        end

        // A load in E cannot be forwarded from M; its consumer must wait one cycle
        assign w_load_use_ch[ch] = !w_rs_zero && (w_rs == bus.wa_e) && bus.we_e && bus.ld_e;

        // Select register; a bubble or flush sends a NOP into E, so its operands come from the RF
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sel_e[ch] <= FWD_RF;
            end else if (w_clear_sel) begin
                r_sel_e[ch] <= FWD_RF;
            end else begin
                r_sel_e[ch] <= w_next_sel[ch];
            end
        end

        // EX operand mux, no added latency
        always_comb begin
            case (fwd_decode(r_sel_e[ch]))
                FWD_M:   w_src[ch] = bus.alu_out_m;
                FWD_W:   w_src[ch] = bus.result_w;
                default: w_src[ch] = bus.rf_e[ch*XLEN +: XLEN];
            endcase
        end
    end

    // Stall is forced low while reset is held so the front end is not frozen during reset
    assign w_hazard    = rst_n && ((|w_load_use_ch) || w_sb_hit);
    assign w_clear_sel = w_hazard || bus.flush_e;

    // Pack per-channel operands and selects onto the bus
    always_comb begin
        bus.src_e = '0;
        bus.sel_e = '0;
        for (int ch = 0; ch < NSRC; ch++) begin
            bus.src_e[ch*XLEN +: XLEN] = w_src[ch];
            bus.sel_e[ch*2 +: 2]       = r_sel_e[ch];
        end
    end

    // Saturating count of stalled decode cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.stall_d   = w_hazard;
    assign bus.bubble_e  = w_hazard;
    assign bus.stall_cnt = r_stall_cnt;

endmodule
